// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES core between two requesters with
// one-deep holding registers, response routing and a core watchdog.
module aes_core_arbiter #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a_stb,
  input  logic [DATA_W-1:0] req_a_data,
  output logic              req_a_ready,
  output logic              resp_a_valid,
  output logic [DATA_W-1:0] resp_a_data,
  input  logic              req_b_stb,
  input  logic [DATA_W-1:0] req_b_data,
  output logic              req_b_ready,
  output logic              resp_b_valid,
  output logic [DATA_W-1:0] resp_b_data,
  output logic              core_stb,
  output logic [DATA_W-1:0] core_din,
  output logic              core_sel,
  input  logic              core_valid,
  input  logic [DATA_W-1:0] core_dout,
  output logic              err_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                 state;
  logic                   pend_a;
  logic                   pend_b;
  logic [DATA_W-1:0]      hold_a;
  logic [DATA_W-1:0]      hold_b;
  logic                   last_grant;
  logic [TIMEOUT_W-1:0]   wdog;
  logic [TIMEOUT_W-1:0]   wdog_inc;
  logic                   pick;

  // Ready is a pure decode of the pending flags, never of an input.
  assign req_a_ready = !pend_a;
  assign req_b_ready = !pend_b;

  // On a tie the requester that did not win last time goes next.
  assign pick     = (pend_a && pend_b) ? !last_grant : pend_b;
  assign wdog_inc = wdog + TIMEOUT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      pend_a       <= 1'b0;
      pend_b       <= 1'b0;
      hold_a       <= '0;
      hold_b       <= '0;
      last_grant   <= 1'b1;
      wdog         <= '0;
      core_stb     <= 1'b0;
      core_din     <= '0;
      core_sel     <= 1'b0;
      resp_a_valid <= 1'b0;
      resp_a_data  <= '0;
      resp_b_valid <= 1'b0;
      resp_b_data  <= '0;
      err_timeout  <= 1'b0;
    end else begin
      core_stb     <= 1'b0;
      resp_a_valid <= 1'b0;
      resp_b_valid <= 1'b0;
      err_timeout  <= 1'b0;

      if (req_a_stb && !pend_a) begin
        pend_a <= 1'b1;
        hold_a <= req_a_data;
      end
      if (req_b_stb && !pend_b) begin
        pend_b <= 1'b1;
        hold_b <= req_b_data;
      end

      // core_sel doubles as the in-flight owner from ISSUE through WAIT.
      case (state)
        IDLE: begin
          if (pend_a || pend_b) begin
            state      <= ISSUE;
            core_stb   <= 1'b1;
            core_din   <= pick ? hold_b : hold_a;
            core_sel   <= pick;
            last_grant <= pick;
          end
        end
        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (core_valid) begin
            if (core_sel) begin
              resp_b_data  <= core_dout;
              resp_b_valid <= 1'b1;
              pend_b       <= 1'b0;
            end else begin
              resp_a_data  <= core_dout;
              resp_a_valid <= 1'b1;
              pend_a       <= 1'b0;
            end
            state <= IDLE;
          end else if (wdog_inc == {TIMEOUT_W{1'b1}}) begin
            // Core went silent: drop the block and free the arbiter.
            err_timeout <= 1'b1;
            if (core_sel) pend_b <= 1'b0;
            else          pend_a <= 1'b0;
            state <= IDLE;
          end else begin
            wdog <= wdog_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Randomized bench for aes_core_arbiter against a timestamp-based
// transaction model (issue cycle, response cycle, timeout deadline).
module tb_aes_core_arbiter;
  localparam int unsigned DW   = 128;
  localparam int unsigned TW   = 8;
  localparam int          TOUT = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_a_stb, req_b_stb;
  logic [DW-1:0] req_a_data, req_b_data;
  logic          req_a_ready, req_b_ready;
  logic          resp_a_valid, resp_b_valid;
  logic [DW-1:0] resp_a_data, resp_b_data;
  logic          core_stb, core_sel, core_valid, err_timeout;
  logic [DW-1:0] core_din, core_dout;

  always #5 clk = ~clk;

  aes_core_arbiter #(.DATA_W(DW), .TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset),
    .req_a_stb(req_a_stb), .req_a_data(req_a_data), .req_a_ready(req_a_ready),
    .resp_a_valid(resp_a_valid), .resp_a_data(resp_a_data),
    .req_b_stb(req_b_stb), .req_b_data(req_b_data), .req_b_ready(req_b_ready),
    .resp_b_valid(resp_b_valid), .resp_b_data(resp_b_data),
    .core_stb(core_stb), .core_din(core_din), .core_sel(core_sel),
    .core_valid(core_valid), .core_dout(core_dout), .err_timeout(err_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: who is pending, what they hold, and when the in-flight block
  // was issued (m_s) and will be answered (m_rc, -1 = never).
  int            cyc;
  bit [1:0]      m_pend;
  logic [DW-1:0] m_hold [2];
  bit            m_last, m_busy, m_owner, m_err;
  int            m_s, m_rc;
  bit [1:0]      m_rv;
  logic [DW-1:0] m_rd [2];
  int            lat_cfg;   // >0 fixed latency, 0 random, -1 silent core

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_pend = '0; m_busy = 0; m_owner = 0; m_last = 1; m_err = 0;
    m_rv = '0; m_rd[0] = '0; m_rd[1] = '0; m_hold[0] = '0; m_hold[1] = '0;
    m_s = -10; m_rc = -1;
  endtask

  task automatic step(input bit rst_low, input bit sa, input logic [DW-1:0] da,
                      input bit sb, input logic [DW-1:0] db, input bit spur);
    bit [1:0] op;
    bit       ob, answer, g;
    check("req_a_ready", DW'(req_a_ready), DW'(!m_pend[0]));
    check("req_b_ready", DW'(req_b_ready), DW'(!m_pend[1]));
    check("core_stb", DW'(core_stb), DW'(m_busy && cyc == m_s));
    if (m_busy) check("core_sel", DW'(core_sel), DW'(m_owner));
    if (m_busy && cyc == m_s) check("core_din", core_din, m_hold[m_owner]);
    check("resp_a_valid", DW'(resp_a_valid), DW'(m_rv[0]));
    check("resp_b_valid", DW'(resp_b_valid), DW'(m_rv[1]));
    if (m_rv[0]) check("resp_a_data", resp_a_data, m_rd[0]);
    if (m_rv[1]) check("resp_b_data", resp_b_data, m_rd[1]);
    check("err_timeout", DW'(err_timeout), DW'(m_err));

    answer     = m_busy && cyc > m_s && cyc == m_rc;
    reset      = !rst_low;
    req_a_stb  = sa; req_a_data = da;
    req_b_stb  = sb; req_b_data = db;
    core_valid = answer || spur;
    core_dout  = answer ? ~m_hold[m_owner] : rnd();

    op = m_pend; ob = m_busy;
    m_rv = '0; m_err = 0;
    if (rst_low) begin
      model_reset();
    end else begin
      if (ob && cyc > m_s) begin
        if (answer) begin
          m_rv[m_owner] = 1; m_rd[m_owner] = ~m_hold[m_owner];
          m_pend[m_owner] = 0; m_busy = 0;
        end else if (cyc == m_s + TOUT) begin
          m_err = 1; m_pend[m_owner] = 0; m_busy = 0;
        end
      end
      if (sa && !op[0]) begin m_pend[0] = 1; m_hold[0] = da; end
      if (sb && !op[1]) begin m_pend[1] = 1; m_hold[1] = db; end
      if (!ob && op != 2'b00) begin
        g = (op == 2'b11) ? !m_last : op[1];
        m_busy = 1; m_owner = g; m_last = g; m_s = cyc + 1;
        if (lat_cfg < 0)      m_rc = -1;
        else if (lat_cfg > 0) m_rc = m_s + lat_cfg;
        else                  m_rc = m_s + int'($urandom_range(1, 12));
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, 0);
  endtask

  initial begin
    logic [DW-1:0] d;
    reset = 0; req_a_stb = 0; req_b_stb = 0; req_a_data = '0; req_b_data = '0;
    core_valid = 0; core_dout = '0;
    cyc = 0; lat_cfg = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_core_din", core_din, '0);
    check("rst_core_sel", DW'(core_sel), '0);
    check("rst_resp_a_data", resp_a_data, '0);
    check("rst_resp_b_data", resp_b_data, '0);

    // Single A request, core answers 5 cycles after core_stb.
    lat_cfg = 5;
    d = 128'h00112233445566778899aabbccddeeff;
    step(0, 1, d, 0, '0, 0);
    idle(14);

    // Dual requests, round-robin across four rounds.
    lat_cfg = 0;
    for (int r = 0; r < 4; r++) begin
      step(0, 1, rnd(), 1, rnd(), 0);
      idle(36);
    end

    // A stb held high with changing data.
    for (int i = 0; i < 40; i++) step(0, 1, rnd(), 0, '0, 0);
    idle(20);

    // Silent core, then a normal request.
    lat_cfg = -1;
    step(0, 1, rnd(), 0, '0, 0);
    lat_cfg = 0;
    idle(TOUT + 10);
    step(0, 1, rnd(), 0, '0, 0);
    idle(20);

    // Spurious core_valid while idle.
    for (int i = 0; i < 6; i++) step(0, 0, '0, 0, '0, 1);

    // Reset during WAIT, late core_valid two cycles later.
    lat_cfg = -1;
    step(0, 0, '0, 1, rnd(), 0);
    idle(4);
    step(1, 0, '0, 0, '0, 0);
    check("midrst_core_din", core_din, '0);
    check("midrst_core_sel", DW'(core_sel), '0);
    check("midrst_resp_b_data", resp_b_data, '0);
    idle(1);
    step(0, 0, '0, 0, '0, 1);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      lat_cfg = ($urandom_range(0, 63) == 0) ? -1 : 0;
      step(0, $urandom_range(0, 2) == 0, rnd(), $urandom_range(0, 2) == 0, rnd(),
           (!m_busy || cyc == m_s) && $urandom_range(0, 7) == 0);
    end
    lat_cfg = 0;
    idle(TOUT + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
